game_countdown: RTL and testbench
=================================

// Module: game_countdown
// PURPOSE
//  Parametrised round timer for the whack-a-mole game.
//  - Counts down from a start value once per tick_i enable.
//  - Supports start, pause/resume, runtime reload and restart.
//  - Flags: low-time warning, one-cycle expiry pulse, BCD digits for the 7-seg driver.
//  - Sits between the 1 Hz tick divider and the game FSM / display mux.
// PARAMETERS
//  WIDTH  7   counter width in bits; START and load_val_i must fit
//  START  30  value loaded at reset and on restart from DONE; must be <= 99 for valid BCD
//  WARN   5   warn_o asserts while 0 < count_o <= WARN
// PORTS
//  clk_i       in   1      system clock
//  reset_i     in   1      asynchronous, active-low reset
//  tick_i      in   1      one-cycle count enable (1 Hz strobe)
//  start_i     in   1      pulse: start (IDLE), resume (PAUSE), restart (DONE)
//  pause_i     in   1      pulse: RUN -> PAUSE
//  load_i      in   1      pulse: load load_val_i and go to IDLE
//  load_val_i  in   WIDTH  reload value
//  count_o     out  WIDTH  current remaining count (registered)
//  running_o   out  1      1 while in RUN
//  done_o      out  1      1 while in DONE
//  expired_o   out  1      one-cycle pulse on entry to DONE (registered)
//  warn_o      out  1      low-time warning
//  tens_o      out  4      BCD tens digit of count_o
//  ones_o      out  4      BCD ones digit of count_o
// BEHAVIOUR
//  - Reset (reset_i=0, async): state IDLE, count_o=START; running_o, done_o, expired_o=0.
//  - States:
//    - IDLE: count held. start_i -> RUN; if count_o==0, go straight to DONE with expired_o pulse.
//    - RUN: each tick_i -> count_o-1.
//      - Tick with count_o==1: count_o=0 and state DONE on the same edge; expired_o=1 for exactly the next cycle.
//      - pause_i -> PAUSE.
//    - PAUSE: count held, tick_i ignored. start_i -> RUN.
//    - DONE: count_o held at 0, done_o=1, tick_i ignored. start_i -> count_o=START, state RUN.
//  - Input priority, same cycle: load_i > pause_i > start_i > tick_i.
//    - load_i in any state: count_o=load_val_i, state IDLE, expired_o not pulsed.
//    - pause_i with tick_i in RUN: pause wins, no decrement.
//    - start_i with tick_i in IDLE/PAUSE: enters RUN, no decrement that cycle.
//  - Latency: a decrement is visible on count_o in the cycle after the tick_i edge.
//    - First decrement after start_i needs a later tick_i.
//  - Decoded outputs (from registers, no extra latency):
//    - running_o = state==RUN.
//    - warn_o = (state RUN or PAUSE) && count_o!=0 && count_o<=WARN.
//  - No underflow: count_o never wraps below 0. Inputs outside the active state are ignored.
//  - Reset mid-operation aborts immediately to the reset values above.
//  - BCD: tens_o/ones_o are combinational from count_o. count_o>99 gives tens_o=ones_o=4'hF.
// STRUCTURE
//  - Shared game package: state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the default START/WARN constants.
//  - Sub-module bin_to_bcd2: WIDTH-bit binary -> two BCD digits, saturating to 4'hF above 99.
//    Reused by the score display.
// TESTING
//  1. Reset, start_i, 30 ticks:
//     - count_o 30->0, one decrement per tick.
//     - expired_o high exactly 1 cycle; done_o=1; warn_o high for counts 5..1.
//  2. RUN at count 12, pause_i + tick_i same cycle:
//     - PAUSE, count_o stays 12 through 5 ticks.
//     - start_i resumes; next tick gives 11.
//  3. DONE, then start_i: count_o=30, running_o=1, done_o=0; next tick gives 29.
//  4. load_i with load_val_i=0 during RUN, then start_i:
//     - IDLE with count 0, then DONE with a single expired_o pulse.
//  5. Assert reset_i low between clock edges mid-RUN:
//     - Outputs reset immediately (async): count_o=30, IDLE.
//  6. count_o=47 -> tens_o=4, ones_o=7. load_val_i=120 -> tens_o=ones_o=4'hF.

Source files
------------

// File: rtl/game_countdown_pkg.sv
// Shared game package: FSM state encoding and default round-timer constants.
package game_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int START_DEFAULT = 30;
  localparam int WARN_DEFAULT  = 5;

  // A round is "active" while it is running or paused; warnings only apply then.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/game_countdown_bin_to_bcd2.sv
// Binary to two BCD digits, saturating both digits to 4'hF above 99.
// Shared with the score display.
module bin_to_bcd2 #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones
);

  logic [31:0] w_val;

  assign w_val = 32'(i_bin);

  // Split into decimal digits, or flag an out-of-range value.
  always_comb begin
    if (w_val > 32'd99) begin
      o_tens = 4'hF;
      o_ones = 4'hF;
    end else begin
      o_tens = 4'(w_val / 32'd10);
      o_ones = 4'(w_val % 32'd10);
    end
  end

endmodule

// File: rtl/game_countdown.sv
// Whack-a-mole round timer: tick-driven countdown with start/pause/reload,
// low-time warning, expiry pulse and BCD digits for the 7-seg driver.
module game_countdown
  import game_countdown_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int START = START_DEFAULT,
  parameter int WARN  = WARN_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             done_o,
  output logic             expired_o,
  output logic             warn_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] WARN_V  = WIDTH'(WARN);
  localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_expired;
  logic             w_expired_nxt;

  // State, count and expiry-pulse registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= ST_IDLE;
      r_count   <= START_V;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  // Next state: load beats everything, then pause, start, tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    if (load_i) begin
      w_count_nxt = load_val_i;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (r_count == ZERO_V) begin
              w_state_nxt   = ST_DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause_i) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick_i) begin
            // The last tick lands on zero and expires on the same edge; never wraps.
            if (r_count <= ONE_V) begin
              w_count_nxt   = ZERO_V;
              w_state_nxt   = ST_DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_count_nxt = r_count - ONE_V;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start_i) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            w_count_nxt = START_V;
            w_state_nxt = ST_RUN;
          end else begin
            w_count_nxt = ZERO_V;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign count_o   = r_count;
  assign expired_o = r_expired;
  assign running_o = (r_state == ST_RUN);
  assign done_o    = (r_state == ST_DONE);
  assign warn_o    = is_active(r_state) && (r_count != ZERO_V) && (r_count <= WARN_V);

  bin_to_bcd2 #(
    .WIDTH (WIDTH)
  ) u_bcd (
    .i_bin  (r_count),
    .o_tens (tens_o),
    .o_ones (ones_o)
  );

endmodule

// File: tb/tb_game_countdown.sv
// Self-checking bench for game_countdown: directed scenarios then random
// pulses, all compared against a behavioural round-timer model.
module tb_game_countdown;

  localparam int WIDTH = 7;
  localparam int START = 30;
  localparam int WARN  = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             clk_i;
  logic             reset_i;
  logic             tick_i;
  logic             start_i;
  logic             pause_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             running_o;
  logic             done_o;
  logic             expired_o;
  logic             warn_o;
  logic [3:0]       tens_o;
  logic [3:0]       ones_o;

  int checks   = 0;
  int failures = 0;

  int m_count;
  int m_mode;
  bit m_exp;
  int exp_pulses;

  game_countdown #(
    .WIDTH (WIDTH),
    .START (START),
    .WARN  (WARN)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .tick_i     (tick_i),
    .start_i    (start_i),
    .pause_i    (pause_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .count_o    (count_o),
    .running_o  (running_o),
    .done_o     (done_o),
    .expired_o  (expired_o),
    .warn_o     (warn_o),
    .tens_o     (tens_o),
    .ones_o     (ones_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_count = START;
    m_mode  = M_IDLE;
    m_exp   = 1'b0;
  endtask

  // One clock of the round timer, written from the behavioural rules.
  task automatic model_step(input bit ld, input bit pa, input bit st, input bit tk, input int lv);
    m_exp = 1'b0;
    if (ld) begin
      m_count = lv;
      m_mode  = M_IDLE;
    end else if (pa && m_mode == M_RUN) begin
      m_mode = M_PAUSE;
    end else if (st && m_mode != M_RUN) begin
      if (m_mode == M_DONE) begin
        m_count = START;
        m_mode  = M_RUN;
      end else if (m_mode == M_IDLE && m_count == 0) begin
        m_mode = M_DONE;
        m_exp  = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (tk && m_mode == M_RUN) begin
      m_count = (m_count > 0) ? m_count - 1 : 0;
      if (m_count == 0) begin
        m_mode = M_DONE;
        m_exp  = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int e_tens;
    int e_ones;
    bit e_warn;
    e_tens = (m_count > 99) ? 15 : m_count / 10;
    e_ones = (m_count > 99) ? 15 : m_count % 10;
    e_warn = (m_mode == M_RUN || m_mode == M_PAUSE) && m_count != 0 && m_count <= WARN;
    chk({tag, ".count"},   32'(count_o),   32'(m_count));
    chk({tag, ".running"}, 32'(running_o), 32'(m_mode == M_RUN));
    chk({tag, ".done"},    32'(done_o),    32'(m_mode == M_DONE));
    chk({tag, ".expired"}, 32'(expired_o), 32'(m_exp));
    chk({tag, ".warn"},    32'(warn_o),    32'(e_warn));
    chk({tag, ".tens"},    32'(tens_o),    32'(e_tens));
    chk({tag, ".ones"},    32'(ones_o),    32'(e_ones));
    if (expired_o === 1'b1) exp_pulses++;
  endtask

  // Drive one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input string tag, input bit ld, input bit pa, input bit st,
                      input bit tk, input int lv);
    load_i     = ld;
    pause_i    = pa;
    start_i    = st;
    tick_i     = tk;
    load_val_i = WIDTH'(lv);
    @(posedge clk_i);
    model_step(ld, pa, st, tk, lv);
    #1;
    check_all(tag);
    load_i  = 1'b0;
    pause_i = 1'b0;
    start_i = 1'b0;
    tick_i  = 1'b0;
  endtask

  initial begin
    int warn_cycles;
    reset_i    = 1'b0;
    tick_i     = 1'b0;
    start_i    = 1'b0;
    pause_i    = 1'b0;
    load_i     = 1'b0;
    load_val_i = '0;
    exp_pulses = 0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;

    // 1: full countdown from 30
    step("t1_idle", 0, 0, 0, 1, 0);
    step("t1_start", 0, 0, 1, 0, 0);
    exp_pulses  = 0;
    warn_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      step("t1_tick", 0, 0, 0, 1, 0);
      chk("t1_seq", 32'(count_o), 32'(29 - i));
      if (warn_o === 1'b1) warn_cycles++;
    end
    step("t1_after", 0, 0, 0, 1, 0);
    step("t1_after2", 0, 0, 0, 0, 0);
    chk("t1_pulses", 32'(exp_pulses), 32'd1);
    chk("t1_warncnt", 32'(warn_cycles), 32'd5);
    chk("t1_done", 32'(done_o), 32'd1);

    // 3 (first half): restart from DONE
    step("t3_restart", 0, 0, 1, 0, 0);
    chk("t3_count30", 32'(count_o), 32'd30);
    chk("t3_running", 32'(running_o), 32'd1);
    step("t3_tick", 0, 0, 0, 1, 0);
    chk("t3_count29", 32'(count_o), 32'd29);

    // 2: pause + tick at 12
    for (int i = 0; i < 17; i++) step("t2_down", 0, 0, 0, 1, 0);
    chk("t2_at12", 32'(count_o), 32'd12);
    step("t2_pause", 0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("t2_hold", 0, 0, 0, 1, 0);
    chk("t2_held", 32'(count_o), 32'd12);
    step("t2_resume", 0, 0, 1, 1, 0);
    chk("t2_nodec", 32'(count_o), 32'd12);
    step("t2_tick", 0, 0, 0, 1, 0);
    chk("t2_11", 32'(count_o), 32'd11);
    for (int i = 0; i < 12; i++) step("t2_drain", 0, 0, 0, 1, 0);
    chk("t2_done", 32'(done_o), 32'd1);

    // 4: load 0 while running, then start -> immediate expiry
    step("t4_start", 0, 0, 1, 0, 0);
    step("t4_tick", 0, 0, 0, 1, 0);
    exp_pulses = 0;
    step("t4_load0", 1, 1, 1, 1, 0);
    chk("t4_cnt0", 32'(count_o), 32'd0);
    step("t4_start0", 0, 0, 1, 0, 0);
    step("t4_post", 0, 0, 0, 1, 0);
    chk("t4_pulses", 32'(exp_pulses), 32'd1);

    // 5: asynchronous reset in the middle of a cycle
    step("t5_load", 1, 0, 0, 0, 20);
    step("t5_start", 0, 0, 1, 0, 0);
    step("t5_tick", 0, 0, 0, 1, 0);
    #3;
    reset_i = 1'b0;
    #1;
    model_reset();
    check_all("t5_async");
    #2;
    reset_i = 1'b1;
    step("t5_post", 0, 0, 0, 1, 0);

    // 6: BCD digits and saturation
    step("t6_47", 1, 0, 0, 0, 47);
    chk("t6_tens4", 32'(tens_o), 32'd4);
    chk("t6_ones7", 32'(ones_o), 32'd7);
    step("t6_120", 1, 0, 0, 0, 120);
    chk("t6_tensF", 32'(tens_o), 32'd15);
    chk("t6_onesF", 32'(ones_o), 32'd15);
    step("t6_99", 1, 0, 0, 0, 99);
    step("t6_100", 1, 0, 0, 0, 100);

    // Random pulses against the model
    for (int i = 0; i < 2000; i++) begin
      bit ld;
      bit pa;
      bit st;
      bit tk;
      int lv;
      ld = ($urandom_range(0, 63) == 0);
      pa = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 2) == 0);
      lv = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 127);
      step("rnd", ld, pa, st, tk, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
